// File: rtl/slave_axi_writer.sv
// AXI3 read-burst front end: takes one AR burst, issues a per-beat address request to the
// bridge engine, buffers the returned data in a 2-entry FIFO and replays it on the R channel.
module slave_axi_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  eng_start,
    output logic                  eng_busy,
    output logic                  eng_req,
    output logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic                  eng_ack,
    input  logic [DATA_WIDTH-1:0] eng_rdata,
    input  logic                  eng_err,
    output logic                  eng_done
);

    // state  | meaning
    // IDLE   | waiting for the engine to grant a read burst
    // AR     | arready high, waiting for the AR handshake
    // BEAT   | issuing beat requests to the engine
    // DRAIN  | all beats fetched, emptying the FIFO onto R
    typedef enum logic [1:0] {S_IDLE, S_AR, S_BEAT, S_DRAIN} state_t;

    state_t state, state_nxt;

    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] addr_sum;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [3:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [3:0]            req_cnt;
    logic [3:0]            rsp_cnt;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_resp [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [3:0]            fifo_count;

    logic ack_ok;
    logic pop;

    assign ack_ok = eng_req && eng_ack;
    assign pop    = rvalid && rready;

    assign rvalid   = (fifo_count != 4'd0);
    assign rdata    = fifo_data[rd_ptr];
    assign rresp    = fifo_resp[rd_ptr];
    assign rlast    = rvalid && (rsp_cnt == len_q);
    assign rid      = id_q;
    assign eng_addr = addr_q;

    // WRAP keeps the bits above the (len+1)<<size boundary and wraps the bits below it
    assign addr_sum  = addr_q + (ADDR_WIDTH'(1) << size_q);
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);

    always_comb begin
        addr_nxt = addr_sum;
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | (addr_sum & wrap_mask);
            default: addr_nxt = addr_sum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        eng_busy  = 1'b1;
        eng_req   = 1'b0;
        case (state)
            S_IDLE: begin
                eng_busy = 1'b0;
                if (eng_start) state_nxt = S_AR;
            end
            S_AR: begin
                arready = 1'b1;
                if (arvalid) state_nxt = S_BEAT;
            end
            S_BEAT: begin
                eng_req = (fifo_count < 4'd2);
                if (ack_ok && (req_cnt == len_q)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && rlast) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else begin
            if (state == S_AR && arvalid) begin
                id_q    <= arid;
                addr_q  <= araddr;
                len_q   <= arlen;
                size_q  <= arsize;
                burst_q <= arburst;
                req_cnt <= '0;
                rsp_cnt <= '0;
            end else begin
                if (ack_ok) begin
                    addr_q  <= addr_nxt;
                    req_cnt <= req_cnt + 4'd1;
                end
                if (pop) rsp_cnt <= rsp_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_resp[0] <= '0;
            fifo_resp[1] <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_count   <= '0;
        end else begin
            if (ack_ok) begin
                fifo_data[wr_ptr] <= eng_rdata;
                fifo_resp[wr_ptr] <= eng_err ? 2'b10 : 2'b00;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (ack_ok && !pop) begin
                fifo_count <= fifo_count + 4'd1;
            end else if (pop && !ack_ok) begin
                fifo_count <= fifo_count - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_done <= 1'b0;
        end else begin
            eng_done <= (state == S_DRAIN) && pop && rlast;
        end
    end

endmodule

// File: tb/tb_slave_axi_writer.sv
// Directed bench for slave_axi_writer: inputs driven and outputs sampled on the falling edge,
// engine model returns data base+beat and reports errors from a per-beat mask.
module tb_slave_axi_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        eng_start;
    logic        eng_busy;
    logic        eng_req;
    logic [31:0] eng_addr;
    logic        eng_ack;
    logic [31:0] eng_rdata;
    logic        eng_err;
    logic        eng_done;

    slave_axi_writer dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .eng_start(eng_start), .eng_busy(eng_busy), .eng_req(eng_req), .eng_addr(eng_addr),
        .eng_ack(eng_ack), .eng_rdata(eng_rdata), .eng_err(eng_err), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          acks;
    int          rsps;
    int          n_beats;
    logic [3:0]  exp_id;
    logic [31:0] data_base;
    logic [15:0] err_mask;
    logic [31:0] exp_addr [16];
    logic [31:0] held_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        acks    = 0;
        rsps    = 0;
        n_beats = int'(len) + 1;
        exp_id  = id;
        eng_ack = 1'b0;
        eng_start = 1'b1;
        @(negedge clk);
        eng_start = 1'b0;
        check("arready_after_start", arready, 1'b1);
        check("busy_after_start", eng_busy, 1'b1);
        check("req_in_ar", eng_req, 1'b0);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        araddr  = 32'hFFFF_FFFF;
        check("arready_after_hs", arready, 1'b0);
        check("req_after_hs", eng_req, 1'b1);
        check("first_eng_addr", eng_addr, addr);
    endtask

    // one engine-side step: ack whenever a request is pending, otherwise wiggle an ignored ack
    task automatic engine_step(input int salt);
        if (eng_req) begin
            if (acks < 16) check("eng_addr", eng_addr, exp_addr[acks]);
            eng_ack   = 1'b1;
            eng_rdata = data_base + 32'(acks);
            eng_err   = (acks < 16) ? err_mask[acks] : 1'b0;
            acks++;
        end else begin
            eng_ack   = 1'($urandom_range(0, 1));
            eng_rdata = 32'hBAD0_0000 | 32'(salt);
            eng_err   = 1'b1;
        end
    endtask

    task automatic service();
        int guard = 0;
        int done_seen = 0;
        while (done_seen == 0 && guard < 200) begin
            if (eng_done) begin
                done_seen = 1;
                check("busy_at_done", eng_busy, 1'b0);
                eng_ack = 1'b0;
            end else begin
                if (rvalid && rready) begin
                    check("rid", rid, exp_id);
                    check("rdata", rdata, data_base + 32'(rsps));
                    check("rresp", rresp, (rsps < 16 && err_mask[rsps]) ? 2'b10 : 2'b00);
                    check("rlast", rlast, (rsps == n_beats - 1));
                    rsps++;
                end
                engine_step(guard);
                @(negedge clk);
                guard++;
            end
        end
        check("done_seen", done_seen, 1);
        check("ack_total", acks, n_beats);
        check("beat_total", rsps, n_beats);
        @(negedge clk);
        check("done_one_cycle", eng_done, 1'b0);
        check("busy_after_done", eng_busy, 1'b0);
        check("rvalid_after_done", rvalid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arvalid = 1'b0; rready = 1'b1; eng_start = 1'b0; eng_ack = 1'b0;
        eng_rdata = '0; eng_err = 1'b0; err_mask = '0; data_base = '0;
        #1;
        check("rst_arready", arready, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_rid", rid, 4'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rresp", rresp, 2'b00);
        check("rst_busy", eng_busy, 1'b0);
        check("rst_req", eng_req, 1'b0);
        check("rst_addr", eng_addr, 32'h0);
        check("rst_done", eng_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_arready", arready, 1'b0);
        check("idle_busy", eng_busy, 1'b0);

        // single beat
        data_base = 32'hDEAD_BEEF; err_mask = '0;
        exp_addr[0] = 32'h100;
        start_ar(4'd3, 32'h100, 4'd0, 3'd2, 2'b01);
        service();

        // INCR len=3
        data_base = 32'h1000_0000;
        exp_addr[0] = 32'h40; exp_addr[1] = 32'h44; exp_addr[2] = 32'h48; exp_addr[3] = 32'h4C;
        start_ar(4'd5, 32'h40, 4'd3, 3'd2, 2'b01);
        service();

        // WRAP len=3 from 0x38
        data_base = 32'h2000_0000;
        exp_addr[0] = 32'h38; exp_addr[1] = 32'h3C; exp_addr[2] = 32'h30; exp_addr[3] = 32'h34;
        start_ar(4'd7, 32'h38, 4'd3, 3'd2, 2'b10);
        service();

        // FIXED len=2
        data_base = 32'h3000_0000;
        exp_addr[0] = 32'h20; exp_addr[1] = 32'h20; exp_addr[2] = 32'h20;
        start_ar(4'd1, 32'h20, 4'd2, 3'd2, 2'b00);
        service();

        // burst type 11 behaves as INCR, byte size
        data_base = 32'h3100_0000;
        exp_addr[0] = 32'h11; exp_addr[1] = 32'h12;
        start_ar(4'd2, 32'h11, 4'd1, 3'd0, 2'b11);
        service();

        // SLVERR on beat 0 only
        data_base = 32'h4000_0000; err_mask = 16'h0001;
        exp_addr[0] = 32'h60; exp_addr[1] = 32'h64;
        start_ar(4'd9, 32'h60, 4'd1, 3'd2, 2'b01);
        service();
        err_mask = '0;

        // backpressure: rready low for 10 cycles
        data_base = 32'h5000_0000;
        exp_addr[0] = 32'h80; exp_addr[1] = 32'h84; exp_addr[2] = 32'h88; exp_addr[3] = 32'h8C;
        start_ar(4'd4, 32'h80, 4'd3, 3'd2, 2'b01);
        rready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            engine_step(i);
            @(negedge clk);
            if (i == 2) held_data = rdata;
            if (i > 2) check("bp_rdata_stable", rdata, held_data);
        end
        check("bp_ack_count", acks, 2);
        check("bp_req_low", eng_req, 1'b0);
        check("bp_rvalid", rvalid, 1'b1);
        check("bp_head", rdata, data_base);
        check("bp_rlast_low", rlast, 1'b0);
        rready = 1'b1;
        service();

        // reset after the second ack of a len=3 burst
        data_base = 32'h6000_0000;
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h204; exp_addr[2] = 32'h208; exp_addr[3] = 32'h20C;
        start_ar(4'd6, 32'h200, 4'd3, 3'd2, 2'b01);
        rready = 1'b0;
        for (int i = 0; i < 20 && acks < 2; i++) begin
            engine_step(i);
            @(negedge clk);
        end
        check("pre_reset_acks", acks, 2);
        eng_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", rvalid, 1'b0);
        check("mid_rst_req", eng_req, 1'b0);
        check("mid_rst_busy", eng_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", rvalid, 1'b0);

        data_base = 32'h7000_0000;
        exp_addr[0] = 32'h300;
        start_ar(4'd11, 32'h300, 4'd0, 3'd2, 2'b01);
        service();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
